// File: rtl/dma_engineer_rd.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : dma_engineer_rd
// Purpose  : Responder for weight fetches. It issues pipelined memory word reads
//            and streams the returned words back to the requesting client.
// Revision : 1.0
// -----------------------------------------------------------------------------
module dma_engineer_rd #(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 8,
  parameter int OST_W           = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  output logic              dma_engineer_ack,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              mem_rd_req,
  input  logic              mem_rd_gnt,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rvalid,
  input  logic [DATA_W-1:0] mem_rd_rdata
);

  localparam logic [OST_W-1:0] c_max_ost = OST_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [ADDR_W-1:0] r_remain_iss, w_iss_nx;
  logic [ADDR_W-1:0] r_remain_ret, w_ret_nx;
  logic [OST_W-1:0]  r_ost, w_ost_nx;
  logic              r_ack, r_dout_en, r_dout_eop, r_mem_req;
  logic [DATA_W-1:0] r_dout;
  logic              w_ack_nx, w_eop_nx, w_req_nx;
  logic              w_issue, w_return;

  assign w_issue  = (r_state == S_RUN) && r_mem_req && mem_rd_gnt;
  assign w_return = (r_state == S_RUN) && mem_rd_rvalid && (r_remain_ret != '0);

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_iss_nx   = r_remain_iss;
    w_ret_nx   = r_remain_ret;
    w_ost_nx   = r_ost;
    w_ack_nx   = 1'b0;
    w_eop_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dma_engineer_req) begin
          w_addr_nx  = dma_engineer_start_addr;
          w_iss_nx   = dma_engineer_length;
          w_ret_nx   = dma_engineer_length;
          w_ost_nx   = '0;
          w_ack_nx   = 1'b1;
          w_state_nx = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nx = (r_remain_ret == '0) ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (w_issue) begin
          w_addr_nx = r_addr + ADDR_W'(1);
          w_iss_nx  = r_remain_iss - ADDR_W'(1);
        end
        if (w_return) begin
          w_ret_nx = r_remain_ret - ADDR_W'(1);
          w_eop_nx = (r_remain_ret == ADDR_W'(1));
        end
        if (w_issue && !(w_return && r_ost != '0)) begin
          w_ost_nx = r_ost + OST_W'(1);
        end else if (!w_issue && w_return && r_ost != '0) begin
          w_ost_nx = r_ost - OST_W'(1);
        end
        // The eop beat is presented while still in RUN, so leave one cycle later.
        if (r_remain_ret == '0) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_req_nx = (w_state_nx == S_RUN) && (w_iss_nx != '0) && (w_ost_nx < c_max_ost);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_remain_iss <= '0;
      r_remain_ret <= '0;
      r_ost        <= '0;
      r_ack        <= 1'b0;
      r_dout_en    <= 1'b0;
      r_dout_eop   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_addr       <= w_addr_nx;
      r_remain_iss <= w_iss_nx;
      r_remain_ret <= w_ret_nx;
      r_ost        <= w_ost_nx;
      r_ack        <= w_ack_nx;
      r_dout_en    <= w_return;
      r_dout_eop   <= w_eop_nx;
      r_mem_req    <= w_req_nx;
      if (w_return) begin
        r_dout <= mem_rd_rdata;
      end
    end
  end

  assign dma_engineer_ack      = r_ack;
  assign dma_engineer_dout_en  = r_dout_en;
  assign dma_engineer_dout_eop = r_dout_eop;
  assign dma_engineer_dout     = r_dout;
  assign mem_rd_req            = r_mem_req;
  assign mem_rd_addr           = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_dma_engineer_rd.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : tb_dma_engineer_rd
// Purpose  : Self-checking bench for dma_engineer_rd with a memory model and
//            an expected-beat scoreboard filled at grant time.
// Revision : 1.0
// -----------------------------------------------------------------------------
module tb_dma_engineer_rd;
  localparam int AW  = 27;
  localparam int DW  = 512;
  localparam int MO  = 8;
  localparam int OW  = 4;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic          ack;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] length = '0;
  logic          dout_en, dout_eop;
  logic [DW-1:0] dout;
  logic          mem_req;
  logic          gnt = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;

  dma_engineer_rd #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .OST_W(OW)) dut (
    .clk(clk), .rst(rst),
    .dma_engineer_req(req), .dma_engineer_ack(ack),
    .dma_engineer_start_addr(start_addr), .dma_engineer_length(length),
    .dma_engineer_dout_en(dout_en), .dma_engineer_dout_eop(dout_eop),
    .dma_engineer_dout(dout),
    .mem_rd_req(mem_req), .mem_rd_gnt(gnt), .mem_rd_addr(mem_addr),
    .mem_rd_rvalid(rvalid), .mem_rd_rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic eop; } exp_t;
  typedef struct { logic [AW-1:0] a; int due; } rd_t;
  exp_t sb[$];
  rd_t  memq[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, acks, grants, beats, eops, req_seen, first_eop_cyc, last_ack_cyc;
  int gnt_pct = 100, release_cnt = 0, drop_after = 1, xfer_len = 0, xfer_grants = 0;
  bit hold = 0, stray = 0, prev_stall = 0;
  logic [AW-1:0] exp_addr = '0, prev_addr = '0;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) begin
      logic [4:0] lane;
      lane = 5'(i);
      r[i*32 +: 32] = {a, lane} ^ 32'hC3A5_0F1E;
    end
    return r;
  endfunction

  task automatic clr_stats();
    acks = 0; grants = 0; beats = 0; eops = 0; req_seen = 0;
    first_eop_cyc = -1; last_ack_cyc = -1; drop_after = 1;
  endtask

  // One clock: observe outputs at the falling edge, then drive the next inputs.
  task automatic step();
    exp_t e;
    rd_t  rd;
    @(negedge clk);
    cyc++;
    if (ack) begin
      acks++; last_ack_cyc = cyc;
      exp_addr = start_addr; xfer_len = int'(length); xfer_grants = 0;
      if (acks >= drop_after) req = 1'b0;
    end
    if (dout_en) begin
      beats++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: dout_en=1 with no beat outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        if (dout !== e.d || dout_eop !== e.eop) begin
          n_fail++;
          $display("FAIL beat_%0d: got data[31:0]=%h eop=%b, expected data[31:0]=%h eop=%b",
                   beats, dout[31:0], dout_eop, e.d[31:0], e.eop);
        end
      end
      if (dout_eop) begin
        eops++;
        if (first_eop_cyc < 0) first_eop_cyc = cyc;
      end
    end else if (dout_eop) begin
      n_tests++; n_fail++;
      $display("FAIL eop_without_en: eop=1 dout_en=0 (cycle %0d)", cyc);
    end
    if (mem_req) req_seen++;
    if (prev_stall) begin
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL addr_stable: got req=%b addr=%h, expected req=1 addr=%h", mem_req, mem_addr, prev_addr);
      end
    end
    rvalid = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc && (!hold || release_cnt > 0)) begin
      rd = memq.pop_front();
      rvalid = 1'b1;
      rdata  = mdata(rd.a);
      if (hold) release_cnt--;
    end else if (stray) begin
      rvalid = 1'b1;
      rdata  = {16{$urandom}};
    end
    gnt = ($urandom_range(99) < gnt_pct);
    if (mem_req && gnt) begin
      grants++; xfer_grants++;
      n_tests++;
      if (mem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL grant_addr: got %h, expected %h", mem_addr, exp_addr);
      end
      rd.a = mem_addr; rd.due = cyc + LAT;
      memq.push_back(rd);
      e.d = mdata(exp_addr); e.eop = (xfer_grants == xfer_len);
      sb.push_back(e);
      exp_addr = exp_addr + AW'(1);
    end
    prev_stall = mem_req && !gnt;
    prev_addr  = mem_addr;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [AW-1:0] l);
    req = 1'b1; start_addr = a; length = l;
  endtask

  task automatic wait_eop(input int n, input int budget);
    int k = 0;
    while (eops < n && k < budget) begin step(); k++; end
    n_tests++;
    if (eops < n) begin
      n_fail++;
      $display("FAIL timeout: eops=%0d, expected %0d within %0d cycles", eops, n, budget);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (ack !== 1'b0 || dout_en !== 1'b0 || dout_eop !== 1'b0 || mem_req !== 1'b0 ||
        dout !== '0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b en=%b eop=%b req=%b addr=%h, expected all 0",
               ack, dout_en, dout_eop, mem_req, mem_addr);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    clr_stats();
    do_req(27'h100, 27'd25);
    wait_eop(1, 300);
    repeat (4) step();
    expect_int("basic_acks", acks, 1);
    expect_int("basic_grants", grants, 25);
    expect_int("basic_beats", beats, 25);
    expect_int("basic_eops", eops, 1);
    expect_int("basic_idle_req", int'(mem_req), 0);
  endtask

  task automatic test_credit();
    clr_stats();
    hold = 1; release_cnt = 0;
    do_req(27'h0, 27'd25);
    repeat (22) step();
    expect_int("credit_grants_full", grants, MO);
    expect_int("credit_req_low", int'(mem_req), 0);
    release_cnt = 1;
    repeat (5) step();
    expect_int("credit_one_more", grants, MO + 1);
    expect_int("credit_req_low2", int'(mem_req), 0);
    hold = 0;
    wait_eop(1, 400);
    expect_int("credit_beats", beats, 25);
  endtask

  task automatic test_wrap_zero();
    clr_stats();
    do_req(27'h7FFFFFE, 27'd4);
    wait_eop(1, 100);
    expect_int("wrap_grants", grants, 4);
    expect_int("wrap_beats", beats, 4);
    repeat (3) step();
    clr_stats();
    do_req(27'h5, 27'd0);
    repeat (8) step();
    expect_int("zero_acks", acks, 1);
    expect_int("zero_mem_req", req_seen, 0);
    expect_int("zero_beats", beats, 0);
    expect_int("zero_eops", eops, 0);
  endtask

  task automatic test_gnt_stall();
    clr_stats();
    gnt_pct = 30;
    do_req(27'h1000, 27'd50);
    wait_eop(1, 2000);
    gnt_pct = 100;
    repeat (6) step();
    expect_int("stall_beats", beats, 50);
    expect_int("stall_eops", eops, 1);
    expect_int("stall_outstanding", memq.size() + sb.size(), 0);
    expect_int("stall_req_low", int'(mem_req), 0);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int b0;
    clr_stats();
    do_req(27'h200, 27'd25);
    while (beats < 10 && k < 300) begin step(); k++; end
    expect_int("mid_reached_10", beats, 10);
    rst = 1'b0; prev_stall = 0;
    #1;
    n_tests++;
    if (ack !== 1'b0 || dout_en !== 1'b0 || dout_eop !== 1'b0 || mem_req !== 1'b0 ||
        dout !== '0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: en=%b eop=%b req=%b addr=%h, expected all 0",
               dout_en, dout_eop, mem_req, mem_addr);
    end
    sb.delete();
    b0 = beats;
    repeat (4) step();
    rst = 1'b1; stray = 1;
    repeat (10) step();
    stray = 0; memq.delete(); prev_stall = 0;
    expect_int("mid_no_beats_after", beats, b0);
    clr_stats();
    do_req(27'h300, 27'd2);
    wait_eop(1, 100);
    repeat (2) step();
    expect_int("mid_new_beats", beats, 2);
    expect_int("mid_new_eops", eops, 1);
  endtask

  task automatic test_back_to_back();
    clr_stats();
    drop_after = 2;
    do_req(27'h40, 27'd3);
    wait_eop(2, 200);
    repeat (3) step();
    expect_int("b2b_acks", acks, 2);
    expect_int("b2b_beats", beats, 6);
    n_tests++;
    if (last_ack_cyc - first_eop_cyc < 2) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d cycles eop->ack, expected >= 2", last_ack_cyc - first_eop_cyc);
    end
    stray = 1;
    repeat (6) step();
    stray = 0;
    repeat (2) step();
    expect_int("b2b_stray_ignored", beats, 6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_wrap_zero();
    test_gnt_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
